vx_ifetch_responder: RTL and testbench



---
 rtl/vx_ifetch_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_vx_ifetch_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ifetch_responder.sv
// vx_ifetch_responder
//
// Fetch-side responder between the warp scheduler and the I-cache. A fetch
// request {uuid, tmask, pc, wid} is passed straight through to the I-cache as
// a word-address read tagged with the warp id, while its metadata is parked in
// a per-warp table. When the I-cache answers, the returned tag selects the
// metadata, and the pair is captured in a single output register for decode.
// Each warp may have at most one fetch in flight.
//
// Clock / reset:
//   clk                    rising-edge clock
//   reset                  synchronous, active-high
//
// Ports:
//   req_valid_i/ready_o    fetch request handshake
//   req_uuid_i/tmask_i/pc_i/wid_i  fetch request payload
//   icache_req_valid_o/ready_i     I-cache read request handshake
//   icache_req_addr_o      word address (req_pc_i[31:2])
//   icache_req_tag_o       warp id used as the read tag
//   icache_rsp_valid_i/ready_o     I-cache read data handshake
//   icache_rsp_data_i/tag_i        instruction word and returned warp id
//   rsp_valid_o/ready_i    fetch response handshake toward decode
//   rsp_uuid_o/tmask_o/pc_o/wid_o/instr_o  registered fetch response
//   pending_warps_o        per-warp in-flight flags
//   tag_error_o            sticky: a response arrived for an idle warp
//   busy_o                 any fetch in flight or a response held
//   perf_stall_cycles_o    cycles with req_valid_i & ~req_ready_o
//   perf_fetched_instrs_o  responses accepted by decode
//
// Build option:
//   IFETCH_PERF_EN  when defined, adds the two 64-bit performance counters and
//                   their ports. Without it the block is otherwise identical.

module vx_ifetch_responder #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned UUID_BITS   = 44,
  parameter int unsigned NW          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,

  // Fetch request from the warp scheduler
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [UUID_BITS-1:0]   req_uuid_i,
  input  logic [NUM_THREADS-1:0] req_tmask_i,
  input  logic [31:0]            req_pc_i,
  input  logic [NW-1:0]          req_wid_i,

  // I-cache read request
  output logic                   icache_req_valid_o,
  input  logic                   icache_req_ready_i,
  output logic [29:0]            icache_req_addr_o,
  output logic [NW-1:0]          icache_req_tag_o,

  // I-cache read response
  input  logic                   icache_rsp_valid_i,
  output logic                   icache_rsp_ready_o,
  input  logic [31:0]            icache_rsp_data_i,
  input  logic [NW-1:0]          icache_rsp_tag_i,

  // Fetch response toward decode
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [UUID_BITS-1:0]   rsp_uuid_o,
  output logic [NUM_THREADS-1:0] rsp_tmask_o,
  output logic [31:0]            rsp_pc_o,
  output logic [NW-1:0]          rsp_wid_o,
  output logic [31:0]            rsp_instr_o,

  // Status
  output logic [NUM_WARPS-1:0]   pending_warps_o,
  output logic                   tag_error_o,
  output logic                   busy_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [63:0]            perf_stall_cycles_o,
  output logic [63:0]            perf_fetched_instrs_o
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_WARPS-1:0]   pending_q, pending_d;
  logic                   tag_error_q, tag_error_d;

  // Per-warp request metadata, indexed by warp id
  logic [UUID_BITS-1:0]   meta_uuid_q  [NUM_WARPS];
  logic [NUM_THREADS-1:0] meta_tmask_q [NUM_WARPS];
  logic [31:0]            meta_pc_q    [NUM_WARPS];

  // Output register
  logic                   rsp_valid_q, rsp_valid_d;
  logic [UUID_BITS-1:0]   rsp_uuid_q, rsp_uuid_d;
  logic [NUM_THREADS-1:0] rsp_tmask_q, rsp_tmask_d;
  logic [31:0]            rsp_pc_q, rsp_pc_d;
  logic [NW-1:0]          rsp_wid_q, rsp_wid_d;
  logic [31:0]            rsp_instr_q, rsp_instr_d;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic req_blocked;
  logic req_fire;
  logic icache_rsp_fire;
  logic rsp_tag_pending;

  // Blocking uses the registered flags, so a warp whose response fires this
  // cycle can only issue again from the next cycle on.
  assign req_blocked        = pending_q[req_wid_i];
  assign icache_req_valid_o = req_valid_i & ~req_blocked;
  assign req_ready_o        = icache_req_ready_i & ~req_blocked;
  assign icache_req_addr_o  = req_pc_i[31:2];
  assign icache_req_tag_o   = req_wid_i;
  assign req_fire           = req_valid_i & req_ready_o;

  assign icache_rsp_ready_o = ~rsp_valid_q | rsp_ready_i;
  assign icache_rsp_fire    = icache_rsp_valid_i & icache_rsp_ready_o;
  assign rsp_tag_pending    = pending_q[icache_rsp_tag_i];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (icache_rsp_fire) begin
      pending_d[icache_rsp_tag_i] = 1'b0;
    end
    // A request can only fire for a warp that is idle, so it never races a
    // legitimate clear of the same warp.
    if (req_fire) begin
      pending_d[req_wid_i] = 1'b1;
    end
  end

  always_comb begin
    tag_error_d = tag_error_q | (icache_rsp_fire & ~rsp_tag_pending);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_uuid_d  = rsp_uuid_q;
    rsp_tmask_d = rsp_tmask_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_wid_d   = rsp_wid_q;
    rsp_instr_d = rsp_instr_q;
    if (icache_rsp_fire) begin
      // Loads even on a tag error; the metadata is whatever the table holds.
      rsp_valid_d = 1'b1;
      rsp_uuid_d  = meta_uuid_q[icache_rsp_tag_i];
      rsp_tmask_d = meta_tmask_q[icache_rsp_tag_i];
      rsp_pc_d    = meta_pc_q[icache_rsp_tag_i];
      rsp_wid_d   = icache_rsp_tag_i;
      rsp_instr_d = icache_rsp_data_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      tag_error_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_uuid_q  <= '0;
      rsp_tmask_q <= '0;
      rsp_pc_q    <= '0;
      rsp_wid_q   <= '0;
      rsp_instr_q <= '0;
    end else begin
      pending_q   <= pending_d;
      tag_error_q <= tag_error_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_uuid_q  <= rsp_uuid_d;
      rsp_tmask_q <= rsp_tmask_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_wid_q   <= rsp_wid_d;
      rsp_instr_q <= rsp_instr_d;
    end
  end

  // Metadata is cleared on reset so a stray response never forwards X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_WARPS); i++) begin
        meta_uuid_q[i]  <= '0;
        meta_tmask_q[i] <= '0;
        meta_pc_q[i]    <= '0;
      end
    end else if (req_fire) begin
      meta_uuid_q[req_wid_i]  <= req_uuid_i;
      meta_tmask_q[req_wid_i] <= req_tmask_i;
      meta_pc_q[req_wid_i]    <= req_pc_i;
    end
  end

  // Responses for an idle warp are flagged at runtime; the data still flows.
  always_ff @(posedge clk) begin
    if (!reset && icache_rsp_fire) begin
      assert (rsp_tag_pending)
      else $warning("vx_ifetch_responder: response for idle warp %0d", icache_rsp_tag_i);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_uuid_o      = rsp_uuid_q;
  assign rsp_tmask_o     = rsp_tmask_q;
  assign rsp_pc_o        = rsp_pc_q;
  assign rsp_wid_o       = rsp_wid_q;
  assign rsp_instr_o     = rsp_instr_q;
  assign pending_warps_o = pending_q;
  assign tag_error_o     = tag_error_q;
  assign busy_o          = (|pending_q) | rsp_valid_q;

`ifdef IFETCH_PERF_EN
  logic [63:0] perf_stall_q, perf_stall_d;
  logic [63:0] perf_fetched_q, perf_fetched_d;

  always_comb begin
    perf_stall_d   = perf_stall_q;
    perf_fetched_d = perf_fetched_q;
    if (req_valid_i & ~req_ready_o) begin
      perf_stall_d = perf_stall_q + 64'd1;
    end
    if (rsp_valid_q & rsp_ready_i) begin
      perf_fetched_d = perf_fetched_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q   <= '0;
      perf_fetched_q <= '0;
    end else begin
      perf_stall_q   <= perf_stall_d;
      perf_fetched_q <= perf_fetched_d;
    end
  end

  assign perf_stall_cycles_o   = perf_stall_q;
  assign perf_fetched_instrs_o = perf_fetched_q;
`endif

endmodule

// File: tb/tb_vx_ifetch_responder.sv
// Directed bench for vx_ifetch_responder. The bench plays both the warp
// scheduler and the I-cache; every expected value is hand-derived.

module tb_vx_ifetch_responder;

  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned UUID_BITS   = 44;
  localparam int unsigned NW          = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic [UUID_BITS-1:0]   req_uuid;
  logic [NUM_THREADS-1:0] req_tmask;
  logic [31:0]            req_pc;
  logic [NW-1:0]          req_wid;
  logic                   icache_req_valid;
  logic                   icache_req_ready;
  logic [29:0]            icache_req_addr;
  logic [NW-1:0]          icache_req_tag;
  logic                   icache_rsp_valid;
  logic                   icache_rsp_ready;
  logic [31:0]            icache_rsp_data;
  logic [NW-1:0]          icache_rsp_tag;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [UUID_BITS-1:0]   rsp_uuid;
  logic [NUM_THREADS-1:0] rsp_tmask;
  logic [31:0]            rsp_pc;
  logic [NW-1:0]          rsp_wid;
  logic [31:0]            rsp_instr;
  logic [NUM_WARPS-1:0]   pending_warps;
  logic                   tag_error;
  logic                   busy;
`ifdef IFETCH_PERF_EN
  logic [63:0]            perf_stall_cycles;
  logic [63:0]            perf_fetched_instrs;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  vx_ifetch_responder #(
    .NUM_WARPS   (NUM_WARPS),
    .NUM_THREADS (NUM_THREADS),
    .UUID_BITS   (UUID_BITS),
    .NW          (NW)
  ) u_dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .req_uuid_i            (req_uuid),
    .req_tmask_i           (req_tmask),
    .req_pc_i              (req_pc),
    .req_wid_i             (req_wid),
    .icache_req_valid_o    (icache_req_valid),
    .icache_req_ready_i    (icache_req_ready),
    .icache_req_addr_o     (icache_req_addr),
    .icache_req_tag_o      (icache_req_tag),
    .icache_rsp_valid_i    (icache_rsp_valid),
    .icache_rsp_ready_o    (icache_rsp_ready),
    .icache_rsp_data_i     (icache_rsp_data),
    .icache_rsp_tag_i      (icache_rsp_tag),
    .rsp_valid_o           (rsp_valid),
    .rsp_ready_i           (rsp_ready),
    .rsp_uuid_o            (rsp_uuid),
    .rsp_tmask_o           (rsp_tmask),
    .rsp_pc_o              (rsp_pc),
    .rsp_wid_o             (rsp_wid),
    .rsp_instr_o           (rsp_instr),
    .pending_warps_o       (pending_warps),
    .tag_error_o           (tag_error),
    .busy_o                (busy)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cycles_o   (perf_stall_cycles),
    .perf_fetched_instrs_o (perf_fetched_instrs)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NW-1:0] wid, input logic [31:0] pc,
                           input logic [UUID_BITS-1:0] uuid, input logic [3:0] tmask);
    req_valid = 1'b1;
    req_wid   = wid;
    req_pc    = pc;
    req_uuid  = uuid;
    req_tmask = tmask;
  endtask

  task automatic drive_icache_rsp(input logic [NW-1:0] tag, input logic [31:0] data);
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = tag;
    icache_rsp_data  = data;
  endtask

  initial begin
    reset            = 1'b1;
    req_valid        = 1'b0;
    req_uuid         = '0;
    req_tmask        = '0;
    req_pc           = '0;
    req_wid          = '0;
    icache_req_ready = 1'b1;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    icache_rsp_tag   = '0;
    rsp_ready        = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_pending", 64'(pending_warps), 64'd0);
    check("rst_tag_error", 64'(tag_error), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_uuid", 64'(rsp_uuid), 64'd0);
    check("rst_rsp_pc", 64'(rsp_pc), 64'd0);
    check("rst_rsp_instr", 64'(rsp_instr), 64'd0);
    check("rst_icache_req_valid", 64'(icache_req_valid), 64'd0);

    // Single fetch, I-cache answers 3 cycles later
    drive_req(2'd0, 32'h8000_0000, 44'd5, 4'h1);
    #1;
    check("single_icache_valid", 64'(icache_req_valid), 64'd1);
    check("single_req_ready", 64'(req_ready), 64'd1);
    check("single_addr", 64'(icache_req_addr), 64'h2000_0000);
    check("single_tag", 64'(icache_req_tag), 64'd0);
    step();
    req_valid = 1'b0;
    check("single_pending", 64'(pending_warps), 64'h1);
    check("single_busy", 64'(busy), 64'd1);
    step();
    step();
    drive_icache_rsp(2'd0, 32'h0000_0013);
    #1;
    check("single_icache_rsp_ready", 64'(icache_rsp_ready), 64'd1);
    step();
    icache_rsp_valid = 1'b0;
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_uuid", 64'(rsp_uuid), 64'd5);
    check("single_rsp_pc", 64'(rsp_pc), 64'h8000_0000);
    check("single_rsp_tmask", 64'(rsp_tmask), 64'h1);
    check("single_rsp_wid", 64'(rsp_wid), 64'd0);
    check("single_rsp_instr", 64'(rsp_instr), 64'h13);
    check("single_pending_clr", 64'(pending_warps), 64'h0);
    step();
    check("single_rsp_drain", 64'(rsp_valid), 64'd0);

    // Per-warp blocking
    drive_req(2'd2, 32'h0000_0040, 44'd7, 4'h5);
    step();
    check("blk_pending2", 64'(pending_warps), 64'h4);
    drive_req(2'd2, 32'h0000_0044, 44'd8, 4'h6);
    #1;
    check("blk_req_ready", 64'(req_ready), 64'd0);
    check("blk_icache_valid", 64'(icache_req_valid), 64'd0);
    drive_req(2'd3, 32'h0000_0080, 44'd9, 4'hF);
    #1;
    check("blk_w3_ready", 64'(req_ready), 64'd1);
    step();
    check("blk_pending23", 64'(pending_warps), 64'hC);
    // Warp 2 response and a new warp-2 request in the same cycle
    drive_req(2'd2, 32'h0000_0044, 44'd8, 4'h6);
    drive_icache_rsp(2'd2, 32'h0000_00AA);
    #1;
    check("blk_same_cycle_ready", 64'(req_ready), 64'd0);
    step();
    icache_rsp_valid = 1'b0;
    check("blk_rsp_uuid", 64'(rsp_uuid), 64'd7);
    check("blk_pending3", 64'(pending_warps), 64'h8);
    check("blk_reissue_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check("blk_reissue_pending", 64'(pending_warps), 64'hC);
    drive_icache_rsp(2'd3, 32'h0000_00BB);
    step();
    check("blk_w3_uuid", 64'(rsp_uuid), 64'd9);
    check("blk_w3_instr", 64'(rsp_instr), 64'hBB);
    drive_icache_rsp(2'd2, 32'h0000_00CC);
    step();
    icache_rsp_valid = 1'b0;
    check("blk_w2b_uuid", 64'(rsp_uuid), 64'd8);
    check("blk_w2b_pc", 64'(rsp_pc), 64'h44);
    step();
    check("blk_idle_pending", 64'(pending_warps), 64'h0);

    // Out-of-order responses
    drive_req(2'd1, 32'h0000_0100, 44'h11, 4'h3);
    step();
    drive_req(2'd3, 32'h0000_0200, 44'h33, 4'hC);
    step();
    req_valid = 1'b0;
    drive_icache_rsp(2'd3, 32'h0000_0333);
    step();
    check("ooo_a_pc", 64'(rsp_pc), 64'h200);
    check("ooo_a_uuid", 64'(rsp_uuid), 64'h33);
    check("ooo_a_tmask", 64'(rsp_tmask), 64'hC);
    check("ooo_a_wid", 64'(rsp_wid), 64'd3);
    drive_icache_rsp(2'd1, 32'h0000_0111);
    step();
    icache_rsp_valid = 1'b0;
    check("ooo_b_valid", 64'(rsp_valid), 64'd1);
    check("ooo_b_pc", 64'(rsp_pc), 64'h100);
    check("ooo_b_uuid", 64'(rsp_uuid), 64'h11);
    check("ooo_b_tmask", 64'(rsp_tmask), 64'h3);
    check("ooo_b_instr", 64'(rsp_instr), 64'h111);
    step();
    check("ooo_drain", 64'(rsp_valid), 64'd0);
    check("ooo_pending", 64'(pending_warps), 64'h0);

    // Backpressure with a queued I-cache response
    drive_req(2'd0, 32'h0000_0300, 44'h40, 4'h1);
    step();
    drive_req(2'd1, 32'h0000_0304, 44'h41, 4'h2);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    drive_icache_rsp(2'd0, 32'h0000_00D0);
    step();
    drive_icache_rsp(2'd1, 32'h0000_00D1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_icache_rsp_ready", 64'(icache_rsp_ready), 64'd0);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_pc", 64'(rsp_pc), 64'h300);
      check("bp_rsp_instr", 64'(rsp_instr), 64'hD0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(icache_rsp_ready), 64'd1);
    step();
    icache_rsp_valid = 1'b0;
    check("bp_next_valid", 64'(rsp_valid), 64'd1);
    check("bp_next_pc", 64'(rsp_pc), 64'h304);
    check("bp_next_instr", 64'(rsp_instr), 64'hD1);
    step();
    check("bp_drain_valid", 64'(rsp_valid), 64'd0);
    check("bp_busy", 64'(busy), 64'd0);

    // Tag error: warp 1 is idle, stale metadata (pc 0x304) is forwarded
    drive_icache_rsp(2'd1, 32'h0000_0E0E);
    step();
    icache_rsp_valid = 1'b0;
    check("err_flag", 64'(tag_error), 64'd1);
    check("err_rsp_valid", 64'(rsp_valid), 64'd1);
    check("err_stale_pc", 64'(rsp_pc), 64'h304);
    check("err_instr", 64'(rsp_instr), 64'hE0E);
    step();
    step();
    check("err_sticky", 64'(tag_error), 64'd1);
    drive_req(2'd0, 32'h0000_0500, 44'h50, 4'h1);
    step();
    req_valid = 1'b0;
    check("err_pending0", 64'(pending_warps), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_pending", 64'(pending_warps), 64'h0);
    check("rst2_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst2_tag_error", 64'(tag_error), 64'd0);
    check("rst2_busy", 64'(busy), 64'd0);

`ifdef IFETCH_PERF_EN
    check("perf_rst_stall", perf_stall_cycles, 64'd0);
    check("perf_rst_fetched", perf_fetched_instrs, 64'd0);
    icache_req_ready = 1'b0;
    drive_req(2'd0, 32'h0000_0600, 44'h60, 4'h1);
    repeat (7) step();
    icache_req_ready = 1'b1;
    step();
    drive_req(2'd1, 32'h0000_0604, 44'h61, 4'h1);
    step();
    drive_req(2'd2, 32'h0000_0608, 44'h62, 4'h1);
    step();
    req_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      drive_icache_rsp(NW'(w), 32'h100 + 32'(w));
      step();
    end
    icache_rsp_valid = 1'b0;
    step();
    check("perf_stall", perf_stall_cycles, 64'd7);
    check("perf_fetched", perf_fetched_instrs, 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
